uart_tx_fsm: RTL and testbench

//  Sequencing controller for the UART TX datapath. Accepts a frame request and drives
//  the serializer enable and the output mux select through start, data, optional

---
 rtl/uart_tx_pkg.sv | 37 +++
 rtl/uart_tx_fsm_if.sv | 38 +++
 rtl/uart_tx_wdog.sv | 36 +++
 rtl/uart_tx_fsm.sv | 115 +++++++++++
 tb/tb_uart_tx_fsm.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART TX sequencing controller.
//   state_t        : FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   MUX_*          : output mux select codes, also used by tx_mux
//   mux_for_state  : maps an FSM state onto the mux select it drives
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Anything that is not an active frame phase keeps the line at the
  // stop/idle level, so the default covers IDLE and STOP alike.
  function automatic logic [1:0] mux_for_state(input state_t s);
    logic [1:0] sel;
    sel = MUX_STOP;
    case (s)
      START:   sel = MUX_START;
      DATA:    sel = MUX_DATA;
      PARITY:  sel = MUX_PAR;
      default: sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm_if
// Bundles the frame-request handshake and the serializer/mux control lines
// of the UART TX controller.
//   Data_Valid  : frame request from the upstream source
//   PAR_EN      : parity phase enable, taken when a request is accepted
//   ser_done    : serializer is presenting its last data bit
//   ser_en      : serializer shift enable
//   mux_sel     : tx_mux select (start / stop-idle / data / parity)
//   busy        : frame in progress
//   data_accept : one-cycle pulse while the START phase is on the line
//   frame_err   : sticky stalled-serializer flag
// modport slave  : the controller side
// modport master : the upstream source / serializer side
// ---------------------------------------------------------------------------
interface uart_tx_fsm_if;
  import uart_tx_pkg::*;

  logic       Data_Valid;
  logic       PAR_EN;
  logic       ser_done;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;
  logic       data_accept;
  logic       frame_err;

  modport slave (
    input  Data_Valid, PAR_EN, ser_done,
    output ser_en, mux_sel, busy, data_accept, frame_err
  );

  modport master (
    output Data_Valid, PAR_EN, ser_done,
    input  ser_en, mux_sel, busy, data_accept, frame_err
  );

endinterface

// File: rtl/uart_tx_wdog.sv
// ---------------------------------------------------------------------------
// uart_tx_wdog
// Clearable up-counter with a terminal-count flag, used to detect a
// serializer that never reports ser_done.
//   CLK   : clock
//   RST   : synchronous active-high reset
//   clr   : synchronous clear (wins over en)
//   en    : count enable
//   tc    : high while the count equals LIMIT
// ---------------------------------------------------------------------------
module uart_tx_wdog #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 9
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
// Sequencing controller for the UART TX datapath. Takes a frame request and
// walks the serializer enable and tx_mux select through the start, data,
// optional parity and stop phases. A watchdog forces the frame to STOP and
// raises a sticky frame_err if the serializer never reports ser_done.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : uart_tx_fsm_if.slave (request handshake + serializer/mux control)
// Parameters:
//   DATA_WIDTH : bits per frame, sets the watchdog limit
//   STOP_BITS  : stop-bit cycles per frame (1 or 2)
// ---------------------------------------------------------------------------
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fsm_if.slave   bus
);

  localparam int         WDOG_W    = $clog2(DATA_WIDTH + 2);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state;
  state_t     next_state;
  logic       par_en_q;
  logic [1:0] stop_cnt;
  logic       stop_last;
  logic       wdog_tc;
  logic       wdog_timeout;

  logic       ser_en_q;
  logic [1:0] mux_sel_q;
  logic       busy_q;
  logic       data_accept_q;
  logic       frame_err_q;

  assign stop_last    = (stop_cnt == STOP_LAST);
  // ser_done takes priority: a serializer finishing on the limit cycle is
  // a good frame, not a stall.
  assign wdog_timeout = (state == DATA) && !bus.ser_done && wdog_tc;

  // The watchdog restarts for every frame and only advances while data
  // bits are being shifted out.
  uart_tx_wdog #(
    .WIDTH (WDOG_W),
    .LIMIT (DATA_WIDTH + 1)
  ) u_wdog (
    .CLK (CLK),
    .RST (RST),
    .clr (next_state == START),
    .en  (state == DATA),
    .tc  (wdog_tc)
  );

  // Next-state decode. Data_Valid is only looked at in IDLE and on the final
  // stop cycle, which gives back-to-back frames without an idle gap and no
  // request queueing. Illegal encodings fall back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.Data_Valid) next_state = START;
      START:   next_state = DATA;
      DATA: begin
        if (bus.ser_done) next_state = par_en_q ? PARITY : STOP;
        else if (wdog_tc) next_state = STOP;
      end
      PARITY:  next_state = STOP;
      STOP: begin
        if (stop_last) next_state = bus.Data_Valid ? START : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State plus registered outputs. Outputs are decoded from next_state so
  // they change on the same edge as the state they describe. PAR_EN is
  // captured only when a frame starts, so mid-frame changes are harmless.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ser_en_q      <= 1'b0;
      mux_sel_q     <= MUX_STOP;
      busy_q        <= 1'b0;
      data_accept_q <= 1'b0;
      frame_err_q   <= 1'b0;
      par_en_q      <= 1'b0;
      stop_cnt      <= '0;
    end else begin
      state         <= next_state;
      ser_en_q      <= (next_state == DATA);
      mux_sel_q     <= mux_for_state(next_state);
      busy_q        <= (next_state != IDLE);
      data_accept_q <= (next_state == START);
      if (next_state == START) begin
        par_en_q <= bus.PAR_EN;
        stop_cnt <= '0;
      end else if (state == STOP && !stop_last) begin
        stop_cnt <= stop_cnt + 2'd1;
      end
      if (wdog_timeout) frame_err_q <= 1'b1;
    end
  end

  assign bus.ser_en      = ser_en_q;
  assign bus.mux_sel     = mux_sel_q;
  assign bus.busy        = busy_q;
  assign bus.data_accept = data_accept_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fsm
// Bench for uart_tx_fsm. Two instances share clock and reset: dut1 with one
// stop bit, dut2 with two. A small serializer model per instance raises
// ser_done on the 8th ser_en cycle (or never, when stalled). Expected
// per-cycle outputs are queued when a frame is requested and compared
// against the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_fsm;

  typedef struct packed {
    logic [1:0] mux;
    logic       busy;
    logic       ser_en;
    logic       acc;
    logic       err;
  } exp_t;

  typedef struct {
    bit par;
    bit toggle;
    bit stall;
    int exp_len;
    bit exp_err;
  } vec_t;

  localparam logic [1:0] M_START = 2'b00;
  localparam logic [1:0] M_STOP  = 2'b01;
  localparam logic [1:0] M_DATA  = 2'b10;
  localparam logic [1:0] M_PAR   = 2'b11;

  logic CLK = 1'b0;
  logic RST;
  logic stall1;
  logic [4:0] ser_cnt1;
  logic [4:0] ser_cnt2;

  int   checks = 0;
  int   passed = 0;
  bit   model_err1;
  exp_t q1[$];
  exp_t q2[$];
  exp_t mon_e1;
  exp_t mon_e2;
  exp_t act1;
  exp_t act2;
  vec_t vecs[7];

  always #5 CLK = ~CLK;

  uart_tx_fsm_if if1 ();
  uart_tx_fsm_if if2 ();

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (if1.slave)
  );

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (if2.slave)
  );

  // Serializer models: count ser_en cycles, flag the 8th one.
  always @(posedge CLK) ser_cnt1 <= if1.ser_en ? ser_cnt1 + 5'd1 : 5'd0;
  always @(posedge CLK) ser_cnt2 <= if2.ser_en ? ser_cnt2 + 5'd1 : 5'd0;
  assign if1.ser_done = if1.ser_en && (ser_cnt1 == 5'd7) && !stall1;
  assign if2.ser_done = if2.ser_en && (ser_cnt2 == 5'd7);

  assign act1 = {if1.mux_sel, if1.busy, if1.ser_en, if1.data_accept, if1.frame_err};
  assign act2 = {if2.mux_sel, if2.busy, if2.ser_en, if2.data_accept, if2.frame_err};

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  function automatic exp_t mk(input logic [1:0] m, input logic b, input logic s,
                              input logic a, input logic e);
    return {m, b, s, a, e};
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    if (d == 1) q1.push_back(e);
    else        q2.push_back(e);
  endtask

  // Expected outputs for one frame, START through the last stop cycle.
  task automatic push_frame(input int d, input bit par, input bit stall,
                            input int stop_bits, input bit err_in);
    int n_data;
    n_data = stall ? 10 : 8;
    push_exp(d, mk(M_START, 1'b1, 1'b0, 1'b1, err_in));
    for (int i = 0; i < n_data; i++) push_exp(d, mk(M_DATA, 1'b1, 1'b1, 1'b0, err_in));
    if (par && !stall) push_exp(d, mk(M_PAR, 1'b1, 1'b0, 1'b0, err_in));
    for (int i = 0; i < stop_bits; i++)
      push_exp(d, mk(M_STOP, 1'b1, 1'b0, 1'b0, err_in | stall));
  endtask

  // Scoreboard: every falling edge pops one expected record per instance.
  always @(negedge CLK) begin
    if (q1.size() > 0) begin
      mon_e1 = q1.pop_front();
      check_output("seq_dut1", 32'(act1), 32'(mon_e1));
    end
    if (q2.size() > 0) begin
      mon_e2 = q2.pop_front();
      check_output("seq_dut2", 32'(act2), 32'(mon_e2));
    end
  end

  // One frame on dut1. Entered and left just after a rising edge.
  task automatic apply_stimulus(input bit par, input bit toggle, input bit stall,
                                input int exp_len, input bit exp_err, input string tag);
    int busy_n;
    int guard;
    bit err_after;
    busy_n    = 0;
    guard     = 0;
    err_after = model_err1 | stall;
    if1.Data_Valid = 1'b1;
    if1.PAR_EN     = par;
    stall1         = stall;
    push_exp(1, mk(M_STOP, 1'b0, 1'b0, 1'b0, model_err1));
    push_frame(1, par, stall, 1, model_err1);
    push_exp(1, mk(M_STOP, 1'b0, 1'b0, 1'b0, err_after));
    model_err1 = err_after;
    @(posedge CLK); #1;
    if1.Data_Valid = 1'b0;
    while (q1.size() > 0 && guard < 100) begin
      @(negedge CLK); #1;
      if (if1.busy) busy_n++;
      if (toggle) if1.PAR_EN = ~if1.PAR_EN;
      guard++;
    end
    check_output({tag, "_drain"}, q1.size(), 0);
    q1.delete();
    check_output({tag, "_busy_len"}, busy_n, exp_len);
    check_output({tag, "_err"}, 32'(if1.frame_err), 32'(exp_err));
    if1.PAR_EN = 1'b0;
    stall1     = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin : global_timeout
    #100000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : main
    int acc_n;
    int first_acc;
    int gap;

    vecs[0] = '{par: 1'b0, toggle: 1'b0, stall: 1'b0, exp_len: 10, exp_err: 1'b0};
    vecs[1] = '{par: 1'b1, toggle: 1'b0, stall: 1'b0, exp_len: 11, exp_err: 1'b0};
    vecs[2] = '{par: 1'b1, toggle: 1'b1, stall: 1'b0, exp_len: 11, exp_err: 1'b0};
    vecs[3] = '{par: 1'b0, toggle: 1'b1, stall: 1'b0, exp_len: 10, exp_err: 1'b0};
    vecs[4] = '{par: 1'b0, toggle: 1'b0, stall: 1'b1, exp_len: 12, exp_err: 1'b1};
    vecs[5] = '{par: 1'b0, toggle: 1'b0, stall: 1'b0, exp_len: 10, exp_err: 1'b1};
    vecs[6] = '{par: 1'b1, toggle: 1'b0, stall: 1'b1, exp_len: 12, exp_err: 1'b1};

    RST            = 1'b1;
    stall1         = 1'b0;
    model_err1     = 1'b0;
    if1.Data_Valid = 1'b1;
    if1.PAR_EN     = 1'b0;
    if2.Data_Valid = 1'b0;
    if2.PAR_EN     = 1'b0;

    // Request held during two reset edges must not be accepted.
    @(negedge CLK); #1;
    check_output("reset1_dut1", 32'(act1), 32'(mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0)));
    @(posedge CLK); #1;
    check_output("reset2_dut1", 32'(act1), 32'(mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0)));
    check_output("reset2_dut2", 32'(act2), 32'(mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0)));
    RST = 1'b0;

    for (int i = 0; i < 7; i++)
      apply_stimulus(vecs[i].par, vecs[i].toggle, vecs[i].stall,
                     vecs[i].exp_len, vecs[i].exp_err, $sformatf("vec%0d", i));
    check_output("err_sticky", 32'(if1.frame_err), 32'd1);

    // Two stop bits, request held across two frames.
    if2.Data_Valid = 1'b1;
    if2.PAR_EN     = 1'b0;
    push_exp(2, mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
    push_frame(2, 1'b0, 1'b0, 2, 1'b0);
    push_frame(2, 1'b0, 1'b0, 2, 1'b0);
    push_exp(2, mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
    acc_n     = 0;
    first_acc = -1;
    gap       = -1;
    for (int c = 0; c < 40; c++) begin
      if (q2.size() == 0) break;
      @(negedge CLK); #1;
      if (if2.data_accept) begin
        if (acc_n == 0) first_acc = c;
        else gap = c - first_acc;
        acc_n++;
      end
      if (c == 12) if2.Data_Valid = 1'b0;
    end
    check_output("b2b_drain", q2.size(), 0);
    q2.delete();
    check_output("b2b_accepts", acc_n, 2);
    check_output("b2b_gap", gap, 11);
    @(posedge CLK); #1;

    // Reset in the 4th DATA cycle aborts the frame and clears frame_err.
    if1.Data_Valid = 1'b1;
    if1.PAR_EN     = 1'b0;
    @(posedge CLK); #1;
    if1.Data_Valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK); #1;
    check_output("rst_mid_pre", 32'(act1), 32'(mk(M_DATA, 1'b1, 1'b1, 1'b0, 1'b1)));
    @(posedge CLK); #1;
    check_output("rst_mid_post", 32'(act1), 32'(mk(M_STOP, 1'b0, 1'b0, 1'b0, 1'b0)));
    RST        = 1'b0;
    model_err1 = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 10, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
